// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM stage and its data-memory access controller.
package ex_mem_pkg;
  localparam int DATA_W = 32;
  localparam int WADR_W = 5;
  localparam int SIDE_W = 5;

  // Bit positions inside the side-strobe vector
  localparam int SIDE_CYCLES         = 0;
  localparam int SIDE_COPY_TO_RAM    = 1;
  localparam int SIDE_FRAME_FLUSH    = 2;
  localparam int SIDE_GET_BITMAP     = 3;
  localparam int SIDE_SCREEN_INS_OPT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } mem_state_e;
endpackage

// File: rtl/ex_mem_stage_if.sv
// Data-RAM request/acknowledge bus between the EX/MEM stage (master) and the RAM (slave).
interface ex_mem_stage_if #(
  parameter int DATA_W = ex_mem_pkg::DATA_W
);
  logic              DMem_Req;
  logic              DMem_We;
  logic [DATA_W-1:0] DMem_Addr;
  logic [DATA_W-1:0] DMem_WData;
  logic              DMem_Ack;
  logic [DATA_W-1:0] DMem_RData;

  modport master (
    output DMem_Req, DMem_We, DMem_Addr, DMem_WData,
    input  DMem_Ack, DMem_RData
  );

  modport slave (
    input  DMem_Req, DMem_We, DMem_Addr, DMem_WData,
    output DMem_Ack, DMem_RData
  );
endinterface

// File: rtl/mem_access_fsm.sv
// Tracks one outstanding data-memory access: raises the request, stalls the pipe
// until acknowledge, captures load data and spends one DONE cycle releasing the stage.
module mem_access_fsm
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = ex_mem_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              mem_op,
  input  logic              store,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] read_data
);
  mem_state_e        state_q;
  logic [DATA_W-1:0] read_data_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      read_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // An ack with no request pending is ignored entirely
          if (mem_op && dmem_ack) begin
            state_q <= DONE;
            if (!store) read_data_q <= dmem_rdata;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req  = mem_op & (state_q == IDLE);
  assign stall     = dmem_req;
  assign dmem_we   = store;
  assign done      = (state_q == DONE);
  assign read_data = read_data_q;
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches EX results, drives the data RAM through
// mem_access_fsm and presents bubble-gated control strobes to MEM/WB.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = ex_mem_pkg::DATA_W,
  parameter int WADR_W = ex_mem_pkg::WADR_W,
  parameter int SIDE_W = ex_mem_pkg::SIDE_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Flush,
  input  logic              EX_Valid,
  input  logic [DATA_W-1:0] EX_AluResult,
  input  logic [DATA_W-1:0] EX_R2,
  input  logic [DATA_W-1:0] EX_Instr,
  input  logic [DATA_W-1:0] EX_PC,
  input  logic [DATA_W-1:0] EX_PC_plus_four,
  input  logic [WADR_W-1:0] EX_WAdr,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  input  logic              EX_MemToReg,
  input  logic              EX_RegWrite,
  input  logic              EX_JAL,
  input  logic [SIDE_W-1:0] EX_Side,
  ex_mem_stage_if.master    dmem,
  output logic              Stall_Out,
  output logic [DATA_W-1:0] AluResult,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] PC_plus_four,
  output logic [DATA_W-1:0] ReadData,
  output logic [WADR_W-1:0] WAdr,
  output logic              RegWrite,
  output logic              MemToReg,
  output logic              JAL,
  output logic [SIDE_W-1:0] Side,
  output logic              MEM_Valid
);
  logic              valid_q;
  logic [DATA_W-1:0] alu_q, r2_q, instr_q, pc_q, pc4_q;
  logic [WADR_W-1:0] wadr_q;
  logic              mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q, jal_q;
  logic [SIDE_W-1:0] side_q;

  logic mem_op, stall, done;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      r2_q         <= '0;
      instr_q      <= '0;
      pc_q         <= '0;
      pc4_q        <= '0;
      wadr_q       <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      jal_q        <= 1'b0;
      side_q       <= '0;
    end else if (!stall) begin
      // While stalled the whole register holds, so a Flush has no effect that cycle
      valid_q      <= EX_Valid & ~Flush;
      alu_q        <= EX_AluResult;
      r2_q         <= EX_R2;
      instr_q      <= EX_Instr;
      pc_q         <= EX_PC;
      pc4_q        <= EX_PC_plus_four;
      wadr_q       <= EX_WAdr;
      mem_read_q   <= EX_MemRead;
      mem_write_q  <= EX_MemWrite;
      mem_to_reg_q <= EX_MemToReg;
      reg_write_q  <= EX_RegWrite;
      jal_q        <= EX_JAL;
      side_q       <= EX_Side;
    end
  end

  assign mem_op = valid_q & (mem_read_q | mem_write_q);

  mem_access_fsm #(.DATA_W(DATA_W)) u_fsm (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .mem_op    (mem_op),
    .store     (mem_write_q),
    .dmem_ack  (dmem.DMem_Ack),
    .dmem_rdata(dmem.DMem_RData),
    .dmem_req  (dmem.DMem_Req),
    .dmem_we   (dmem.DMem_We),
    .stall     (stall),
    .done      (done),
    .read_data (ReadData)
  );

  assign dmem.DMem_Addr  = alu_q;
  assign dmem.DMem_WData = r2_q;

  assign Stall_Out = stall;
  assign MEM_Valid = valid_q & (~mem_op | done);

  assign AluResult    = alu_q;
  assign R2           = r2_q;
  assign Instr        = instr_q;
  assign PC           = pc_q;
  assign PC_plus_four = pc4_q;
  assign WAdr         = wadr_q;
  assign RegWrite     = reg_write_q & MEM_Valid;
  assign MemToReg     = mem_to_reg_q & MEM_Valid;
  assign JAL          = jal_q & MEM_Valid;
  assign Side         = side_q & {SIDE_W{MEM_Valid}};
endmodule
